input_conditioner: RTL and testbench

- Front-end for all player controls; sits directly upstream of the top-level game state machine and the active level.
- Synchronises the raw board switches and push-buttons into the vga_clock domain and debounces them.
- Emits clean active-high levels plus one-cycle press/release pulses.
- The game FSM consumes start_press (START to LEVEL1); the levels consume left/right/jump levels and jump_press.

---
 rtl/input_pkg.sv | 20 ++
 rtl/debounce_channel.sv | 99 +++++++++
 rtl/input_conditioner.sv | 103 ++++++++++
 tb/tb_input_conditioner.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/input_pkg.sv
// ---------------------------------------------------------------------------
// input_pkg
// Shared types and constants for the player-control input conditioner.
//   debounce_state_t        : accepted value of one debounced channel
//   DEFAULT_DEBOUNCE_CYCLES : 10 ms at 25 MHz
//   SIM_DEBOUNCE_CYCLES     : short debounce window for simulation benches
//   DEFAULT_SYNC_STAGES     : flops per synchroniser chain
// ---------------------------------------------------------------------------
package input_pkg;

    typedef enum logic {
        ACCEPTED_OFF = 1'b0,
        ACCEPTED_ON  = 1'b1
    } debounce_state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;
    localparam int SIM_DEBOUNCE_CYCLES     = 4;
    localparam int DEFAULT_SYNC_STAGES     = 2;

endpackage

// File: rtl/debounce_channel.sv
// ---------------------------------------------------------------------------
// debounce_channel
// One control input: synchroniser chain, optional polarity inversion, and a
// two-state debounce FSM that accepts a new value only after it has been
// seen for DEBOUNCE_CYCLES consecutive cycles.
//   vga_clock : clock, rising edge
//   reset     : asynchronous, active-low
//   raw       : asynchronous board input
//   level     : debounced active-high value (registered)
//   rise      : one-cycle pulse when level goes 0 -> 1
//   fall      : one-cycle pulse when level goes 1 -> 0
// ---------------------------------------------------------------------------
module debounce_channel
    import input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter bit INVERT          = 1'b0
) (
    input  logic vga_clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int                     COUNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [COUNT_W-1:0]     LAST_COUNT = COUNT_W'(DEBOUNCE_CYCLES - 1);
    // The chain resets to the raw idle level so that reset release never
    // looks like an edge on the input.
    localparam logic [SYNC_STAGES-1:0] SYNC_IDLE  = {SYNC_STAGES{INVERT}};

    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   sample;

    debounce_state_t        state, next_state;
    logic [COUNT_W-1:0]     count, next_count;
    logic                   next_rise, next_fall;

    // NOTE: every clocked process uses non-blocking assignments so all flops
    // update together at the edge and ordering between processes is irrelevant.
    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            sync_chain <= SYNC_IDLE;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], raw};
        end
    end

    // Normalised to active-high after the last synchroniser stage.
    assign sample = sync_chain[SYNC_STAGES-1] ^ INVERT;

    // State register; the pulses are registered so no output has a
    // combinational path from the raw pin.
    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            state <= ACCEPTED_OFF;
            count <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= next_state;
            count <= next_count;
            rise  <= next_rise;
            fall  <= next_fall;
        end
    end

    // Next-state logic: count consecutive cycles where the sample differs
    // from the accepted value; any agreeing cycle restarts the count.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        next_state = state;
        next_count = '0;
        next_rise  = 1'b0;
        next_fall  = 1'b0;
        if (sample != (state == ACCEPTED_ON)) begin
            if (count == LAST_COUNT) begin
                if (state == ACCEPTED_OFF) begin
                    next_state = ACCEPTED_ON;
                    next_rise  = 1'b1;
                end else begin
                    next_state = ACCEPTED_OFF;
                    next_fall  = 1'b1;
                end
            end else begin
                next_count = count + 1'b1;
            end
        end
    end

    // Output logic: the level is the state flop itself.
    always_comb begin
        level = (state == ACCEPTED_ON);
    end

endmodule

// File: rtl/input_conditioner.sv
// ---------------------------------------------------------------------------
// input_conditioner
// Synchronises and debounces the player switches and buttons into the
// vga_clock domain and produces clean levels plus press/release pulses.
//   vga_clock        : clock, rising edge
//   reset            : asynchronous, active-low
//   raw_left_switch  : board switch, active-high
//   raw_right_switch : board switch, active-high
//   raw_jump_button  : push-button, polarity set by BUTTONS_ACTIVE_LOW
//   raw_start_button : push-button, polarity set by BUTTONS_ACTIVE_LOW
//   left_level       : debounced left switch
//   right_level      : debounced right switch
//   jump_held        : debounced jump button
//   jump_press       : one-cycle pulse on jump_held rising
//   jump_release     : one-cycle pulse on jump_held falling
//   start_press      : one-cycle pulse on debounced start rising
//   any_activity     : one-cycle pulse when any channel accepts a change
// ---------------------------------------------------------------------------
module input_conditioner
    import input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES    = DEFAULT_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES        = DEFAULT_SYNC_STAGES,
    parameter bit BUTTONS_ACTIVE_LOW = 1'b1
) (
    input  logic vga_clock,
    input  logic reset,
    input  logic raw_left_switch,
    input  logic raw_right_switch,
    input  logic raw_jump_button,
    input  logic raw_start_button,
    output logic left_level,
    output logic right_level,
    output logic jump_held,
    output logic jump_press,
    output logic jump_release,
    output logic start_press,
    output logic any_activity
);

    logic left_rise, left_fall;
    logic right_rise, right_fall;
    logic start_fall;
    // The game only reacts to the start press; the held level is not needed.
    logic unused_start_level;

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES),
        .INVERT          (1'b0)
    ) u_left (
        .vga_clock (vga_clock),
        .reset     (reset),
        .raw       (raw_left_switch),
        .level     (left_level),
        .rise      (left_rise),
        .fall      (left_fall)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES),
        .INVERT          (1'b0)
    ) u_right (
        .vga_clock (vga_clock),
        .reset     (reset),
        .raw       (raw_right_switch),
        .level     (right_level),
        .rise      (right_rise),
        .fall      (right_fall)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES),
        .INVERT          (BUTTONS_ACTIVE_LOW)
    ) u_jump (
        .vga_clock (vga_clock),
        .reset     (reset),
        .raw       (raw_jump_button),
        .level     (jump_held),
        .rise      (jump_press),
        .fall      (jump_release)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES),
        .INVERT          (BUTTONS_ACTIVE_LOW)
    ) u_start (
        .vga_clock (vga_clock),
        .reset     (reset),
        .raw       (raw_start_button),
        .level     (unused_start_level),
        .rise      (start_press),
        .fall      (start_fall)
    );

    // OR of registered pulses only, so still free of any raw-input path.
    assign any_activity = left_rise  | left_fall  | right_rise   | right_fall |
                          jump_press | jump_release | start_press | start_fall;

endmodule

// File: tb/tb_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_input_conditioner
// Directed scenarios with hand-computed edge counts, then randomized input
// activity with occasional resets, checked every cycle against a behavioural
// model: a channel's accepted value flips once the last D synchronised
// samples all disagree with it, where the synchronised sample is simply the
// raw level seen S edges earlier.
// ---------------------------------------------------------------------------
module tb_input_conditioner;
    import input_pkg::*;

    localparam int D = SIM_DEBOUNCE_CYCLES;
    localparam int S = 2;

    logic vga_clock = 1'b0;
    logic reset     = 1'b0;
    logic raw_left_switch  = 1'b0;
    logic raw_right_switch = 1'b0;
    logic raw_jump_button  = 1'b1;
    logic raw_start_button = 1'b1;
    logic left_level, right_level, jump_held, jump_press, jump_release;
    logic start_press, any_activity;

    input_conditioner #(
        .DEBOUNCE_CYCLES    (D),
        .SYNC_STAGES        (S),
        .BUTTONS_ACTIVE_LOW (1'b1)
    ) dut (
        .vga_clock        (vga_clock),
        .reset            (reset),
        .raw_left_switch  (raw_left_switch),
        .raw_right_switch (raw_right_switch),
        .raw_jump_button  (raw_jump_button),
        .raw_start_button (raw_start_button),
        .left_level       (left_level),
        .right_level      (right_level),
        .jump_held        (jump_held),
        .jump_press       (jump_press),
        .jump_release     (jump_release),
        .start_press      (start_press),
        .any_activity     (any_activity)
    );

    always #20 vga_clock = ~vga_clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Channel order: 0 left, 1 right, 2 jump, 3 start (all active-high).
    bit hist [4][S];   // raw samples in flight through the synchroniser
    bit seen [4][D];   // most recent synchronised samples, oldest first
    int seen_n [4];
    bit acc  [4];
    bit m_rise [4];
    bit m_fall [4];

    task model_reset();
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < S; k++) hist[c][k] = 1'b0;
            for (int k = 0; k < D; k++) seen[c][k] = 1'b0;
            seen_n[c] = 0;
            acc[c]    = 1'b0;
            m_rise[c] = 1'b0;
            m_fall[c] = 1'b0;
        end
    endtask

    task model_step();
        bit norm [4];
        bit synced;
        bit all_diff;
        norm[0] = raw_left_switch;
        norm[1] = raw_right_switch;
        norm[2] = ~raw_jump_button;
        norm[3] = ~raw_start_button;
        for (int c = 0; c < 4; c++) begin
            synced = hist[c][0];
            for (int k = 0; k < S - 1; k++) hist[c][k] = hist[c][k+1];
            hist[c][S-1] = norm[c];
            if (seen_n[c] < D) begin
                seen[c][seen_n[c]] = synced;
                seen_n[c]++;
            end else begin
                for (int k = 0; k < D - 1; k++) seen[c][k] = seen[c][k+1];
                seen[c][D-1] = synced;
            end
            m_rise[c] = 1'b0;
            m_fall[c] = 1'b0;
            if (seen_n[c] == D) begin
                all_diff = 1'b1;
                for (int k = 0; k < D; k++) if (seen[c][k] == acc[c]) all_diff = 1'b0;
                if (all_diff) begin
                    acc[c] = ~acc[c];
                    if (acc[c]) m_rise[c] = 1'b1;
                    else        m_fall[c] = 1'b1;
                end
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge vga_clock or negedge reset);
            if (!reset) model_reset();
            else        model_step();
        end
    end

    function automatic logic [6:0] model_vec();
        logic any;
        any = 1'b0;
        for (int c = 0; c < 4; c++) any |= m_rise[c] | m_fall[c];
        return {acc[0], acc[1], acc[2], m_rise[2], m_fall[2], m_rise[3], any};
    endfunction

    logic [6:0] dut_vec;
    assign dut_vec = {left_level, right_level, jump_held, jump_press,
                      jump_release, start_press, any_activity};

    // Every-cycle comparison, sampled 1 time unit after the rising edge.
    initial begin
        forever begin
            @(posedge vga_clock);
            #1;
            check("outputs_vs_model", {25'd0, dut_vec}, {25'd0, model_vec()});
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_edges(input int n);
        repeat (n) @(posedge vga_clock);
        #1;
    endtask

    int rise_edge, fall_edge, n_press, n_release, n_act, n_start;
    int hold [4];
    int reset_hold;

    initial begin
        // Reset with jump held, then release reset with jump still held.
        raw_jump_button = 1'b0;
        repeat (3) @(negedge vga_clock);
        check("reset_outputs_zero", {25'd0, dut_vec}, 32'd0);
        @(negedge vga_clock);
        reset = 1'b1;
        wait_edges(5);
        check("held_through_reset_edge5", {31'd0, jump_held}, 32'd0);
        wait_edges(1);
        check("held_through_reset_edge6", {31'd0, jump_held}, 32'd1);
        check("held_through_reset_press", {31'd0, jump_press}, 32'd1);
        wait_edges(1);
        check("press_one_cycle", {31'd0, jump_press}, 32'd0);
        check("held_stays", {31'd0, jump_held}, 32'd1);
        @(negedge vga_clock);
        raw_jump_button = 1'b1;
        wait_edges(5);
        check("release_edge5", {31'd0, jump_held}, 32'd1);
        wait_edges(1);
        check("release_edge6", {30'd0, jump_held, jump_release}, 32'd1);
        wait_edges(5);

        // Clean press held 20 cycles.
        rise_edge = 0; fall_edge = 0; n_press = 0; n_release = 0; n_act = 0;
        @(negedge vga_clock);
        raw_jump_button = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            if (e > 1) @(negedge vga_clock);
            if (e == 21) raw_jump_button = 1'b1;
            @(posedge vga_clock);
            #1;
            if (jump_held && rise_edge == 0) rise_edge = e;
            if (!jump_held && rise_edge != 0 && fall_edge == 0) fall_edge = e;
            n_press   += int'(jump_press);
            n_release += int'(jump_release);
            n_act     += int'(any_activity);
        end
        check("clean_rise_edge", rise_edge, 32'd6);
        check("clean_fall_edge", fall_edge, 32'd26);
        check("clean_press_count", n_press, 32'd1);
        check("clean_release_count", n_release, 32'd1);
        check("clean_activity_count", n_act, 32'd2);

        // Bounce filter: 2-cycle runs never get through.
        n_start = 0; n_act = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge vga_clock);
            raw_start_button = (i < 30) ? (((i / 2) % 2) == 1) : 1'b1;
            @(posedge vga_clock);
            #1;
            n_start += int'(start_press);
            n_act   += int'(any_activity);
        end
        check("bounce_no_start", n_start, 32'd0);
        check("bounce_no_activity", n_act, 32'd0);

        // Bounce then settle pressed: one press, 6 edges after last change.
        @(negedge vga_clock); raw_start_button = 1'b0;
        @(negedge vga_clock); raw_start_button = 1'b1;
        @(negedge vga_clock); raw_start_button = 1'b0;
        wait_edges(5);
        check("settle_edge5", {31'd0, start_press}, 32'd0);
        wait_edges(1);
        check("settle_edge6", {31'd0, start_press}, 32'd1);
        wait_edges(1);
        check("settle_one_cycle", {31'd0, start_press}, 32'd0);
        @(negedge vga_clock); raw_start_button = 1'b1;
        wait_edges(10);

        // Simultaneous switch rise.
        @(negedge vga_clock);
        raw_left_switch  = 1'b1;
        raw_right_switch = 1'b1;
        wait_edges(5);
        check("simul_edge5", {30'd0, left_level, right_level}, 32'd0);
        wait_edges(1);
        check("simul_edge6", {29'd0, left_level, right_level, any_activity}, 32'd7);
        wait_edges(1);
        check("simul_activity_one_cycle", {31'd0, any_activity}, 32'd0);
        @(negedge vga_clock);
        raw_left_switch  = 1'b0;
        raw_right_switch = 1'b0;
        wait_edges(10);

        // Reset mid-count on the right switch.
        @(negedge vga_clock);
        raw_right_switch = 1'b1;
        wait_edges(5);
        @(negedge vga_clock);
        reset = 1'b0;
        #1;
        check("midcount_reset_level", {31'd0, right_level}, 32'd0);
        wait_edges(2);
        check("midcount_in_reset", {30'd0, right_level, any_activity}, 32'd0);
        @(negedge vga_clock);
        reset = 1'b1;
        wait_edges(5);
        check("midcount_after_edge5", {30'd0, right_level, any_activity}, 32'd0);
        wait_edges(1);
        check("midcount_after_edge6", {30'd0, right_level, any_activity}, 32'd3);

        // Randomized activity with occasional resets.
        for (int c = 0; c < 4; c++) hold[c] = 0;
        reset_hold = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge vga_clock);
            for (int c = 0; c < 4; c++) begin
                if (hold[c] == 0) begin
                    hold[c] = $urandom_range(1, 2 * D + 2);
                    case (c)
                        0: raw_left_switch  = 1'($urandom_range(0, 1));
                        1: raw_right_switch = 1'($urandom_range(0, 1));
                        2: raw_jump_button  = 1'($urandom_range(0, 1));
                        default: raw_start_button = 1'($urandom_range(0, 1));
                    endcase
                end else begin
                    hold[c]--;
                end
            end
            if (reset_hold > 0) begin
                reset_hold--;
                if (reset_hold == 0) reset = 1'b1;
            end else if ($urandom_range(0, 299) == 0) begin
                reset      = 1'b0;
                reset_hold = $urandom_range(1, 3);
            end
        end
        @(negedge vga_clock);
        reset = 1'b1;
        wait_edges(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
